// File: rtl/heat_pixel_writer.sv
// heat_pixel_writer
// Draws one grid node as a square cell of pixels. A rising edge on node_flag
// captures node_center, maps it to an 8-bit heat index and colour, then emits
// the cell's pixels in raster order through a req/ack handshake. The row
// counter walks bottom-up from 0 to height and wraps with a frame_done pulse.
//
// Ports:
//   clk          sole clock
//   reset        synchronous, active-low reset
//   col_index    grid column drawn by this instance
//   height       top row index (rows run 0..height)
//   node_center  signed fixed-point node value
//   node_flag    "node computed" level; rising edge starts a cell
//   pix_ack      pixel buffer accepted the current write
//   pix_req      pixel write request (high exactly in REQ)
//   pix_x/pix_y  pixel coordinates, pix_color pixel colour
//   wr_done      high when no cell draw is in progress
//   frame_done   one-cycle pulse after the top-row cell completes
//   err_overrun  sticky: a node_flag rise arrived while busy
//
// Configuration macro: HEAT_RAMP_EN selects an RGB332 blue-to-red ramp
// instead of grayscale for pix_color.
module heat_pixel_writer #(
    parameter int unsigned X_ORIGIN  = 0,
    parameter int unsigned Y_ORIGIN  = 0,
    parameter int unsigned CELL_LOG2 = 2,
    parameter int unsigned FRAC_BITS = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  col_index,
    input  logic [7:0]  height,
    input  logic [31:0] node_center,
    input  logic        node_flag,
    input  logic        pix_ack,
    output logic        pix_req,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [7:0]  pix_color,
    output logic        wr_done,
    output logic        frame_done,
    output logic        err_overrun
);

    localparam int unsigned CW = (CELL_LOG2 > 0) ? CELL_LOG2 : 1;
    localparam int unsigned XYW = 10;
    localparam logic [CW-1:0] DMAX = CW'((1 << CELL_LOG2) - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        REQ     = 3'd2,
        NEXT    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            flag_q;
    logic            rise;
    logic [7:0]      row_q, row_d;
    logic [CW-1:0]   dx_q, dx_d, dy_q, dy_d;
    logic [XYW-1:0]  x0_q, x0_d, y0_q, y0_d;
    logic [XYW-1:0]  x_d, y_d;
    logic [7:0]      color_d;
    logic            req_d, done_d, frame_d, err_d;
    logic [7:0]      idx_c;
    logic [7:0]      color_c;
    logic [XYW-1:0]  x0_c, y0_c;

    // Rising edge of the column's "node computed" level
    assign rise = node_flag & ~flag_q;

    // Heat index: clamp negatives to 0 and values >= 1.0 to 255
    always_comb begin
        idx_c = 8'(node_center >> (FRAC_BITS - 8));
        if (node_center[31]) begin
            idx_c = 8'd0;
        end else if ((node_center >> FRAC_BITS) != 32'd0) begin
            idx_c = 8'hFF;
        end
    end

    // Colour encoding of the heat index
`ifdef HEAT_RAMP_EN
    assign color_c = {3'(idx_c >> 5), 3'b000, ~2'(idx_c >> 6)};
`else
    assign color_c = idx_c;
`endif

    // Cell origin; row 0 sits at the bottom of the grid
    assign x0_c = 10'(X_ORIGIN) + 10'({2'b00, col_index} << CELL_LOG2);
    assign y0_c = 10'(Y_ORIGIN) + 10'({2'b00, 8'(height - row_q)} << CELL_LOG2);

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x_d     = pix_x;
        y_d     = pix_y;
        color_d = pix_color;
        frame_d = 1'b0;
        // A rise while busy is dropped but remembered
        err_d   = err_overrun | (rise & (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                color_d = color_c;
                x0_d    = x0_c;
                y0_d    = y0_c;
                dx_d    = '0;
                dy_d    = '0;
                x_d     = x0_c;
                y_d     = y0_c;
                state_d = REQ;
            end
            REQ: begin
                if (pix_ack) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                // dx is the inner loop, dy the outer loop
                if (dx_q != DMAX) begin
                    dx_d    = dx_q + CW'(1);
                    x_d     = x0_q + 10'(dx_d);
                    state_d = REQ;
                end else if (dy_q != DMAX) begin
                    dx_d    = '0;
                    dy_d    = dy_q + CW'(1);
                    x_d     = x0_q;
                    y_d     = y0_q + 10'(dy_d);
                    state_d = REQ;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (row_q == height) begin
                    row_d   = 8'd0;
                    frame_d = 1'b1;
                end else begin
                    row_d = row_q + 8'd1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_d  = (state_d == REQ);
        done_d = (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            flag_q      <= 1'b0;
            row_q       <= 8'd0;
            dx_q        <= '0;
            dy_q        <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            pix_req     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_color   <= 8'd0;
            wr_done     <= 1'b1;
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state_q     <= state_d;
            flag_q      <= node_flag;
            row_q       <= row_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            pix_req     <= req_d;
            pix_x       <= x_d;
            pix_y       <= y_d;
            pix_color   <= color_d;
            wr_done     <= done_d;
            frame_done  <= frame_d;
            err_overrun <= err_d;
        end
    end

endmodule

// File: doc/heat_pixel_writer.md
HEAT_PIXEL_WRITER -- requirements
Module: heat_pixel_writer

Interface
REQ-001 SHALL expose parameters, one per line (name, default, meaning):
- X_ORIGIN, 0: screen x of grid column 0.
- Y_ORIGIN, 0: screen y of the grid top edge.
- CELL_LOG2, 2: log2 of the cell edge in pixels; each node is drawn as a square cell.
- FRAC_BITS, 27: fractional bits of the node fixed-point format.

REQ-002 SHALL expose ports, one per line (name, direction, width, meaning):
- clk, in, 1: sole clock.
- reset, in, 1: synchronous, active-low reset.
- col_index, in, 8: grid column drawn by this instance.
- height, in, 8: top row index; rows run 0..height.
- node_center, in, 32: signed fixed-point node value from the paired column.
- node_flag, in, 1: column "node computed" level; its rising edge marks a new valid node.
- pix_ack, in, 1: pixel buffer accepted the current write.
- pix_req, out, 1: pixel write request.
- pix_x, out, 10: pixel x coordinate.
- pix_y, out, 10: pixel y coordinate.
- pix_color, out, 8: pixel colour.
- wr_done, out, 1: no cell draw is in progress; top level ANDs this across columns into the column start.
- frame_done, out, 1: one-cycle pulse after the top-row cell completes.
- err_overrun, out, 1: sticky protocol-violation flag.

Function
REQ-003 SHALL register node_flag every cycle and detect its rising edge (current high, previous low).
REQ-004 SHALL implement states IDLE, CAPTURE, REQ, NEXT, DONE:
- IDLE to CAPTURE on a rising edge.
- CAPTURE to REQ unconditionally.
- REQ to NEXT on pix_ack.
- NEXT to REQ if cell pixels remain, otherwise to DONE.
- DONE to IDLE unconditionally.
REQ-005 CAPTURE SHALL latch node_center and compute the 8-bit index:
- 0 if the value is negative.
- 255 if value[31:FRAC_BITS] is nonzero (value is 1.0 or more).
- Otherwise value[FRAC_BITS-1:FRAC_BITS-8].
REQ-006 Cell origin SHALL be:
- x0 = X_ORIGIN + (col_index << CELL_LOG2).
- y0 = Y_ORIGIN + ((height - row) << CELL_LOG2), so row 0 is drawn at the bottom.
- Coordinates SHALL be truncated to 10 bits.
REQ-007 SHALL emit pixels raster order within the cell: dx is the inner loop and dy the outer loop, each 0..2^CELL_LOG2-1, giving pix_x = x0+dx and pix_y = y0+dy.
REQ-008 pix_req SHALL be high exactly in REQ, with pix_x, pix_y and pix_color held stable until pix_ack is sampled high.
REQ-009 pix_ack SHALL be ignored outside REQ; each accepted pixel costs at least 2 cycles (REQ then NEXT).
REQ-010 First pix_req SHALL assert 2 cycles after the cycle in which the rising edge is detected.
REQ-011 wr_done SHALL be low from CAPTURE through DONE inclusive and high in IDLE.
REQ-012 The internal row counter (8 bits) SHALL update in DONE:
- If row == height: row goes to 0 and frame_done pulses for 1 cycle.
- Otherwise: row increments by 1.
REQ-013 A rising edge detected outside IDLE SHALL be dropped (no extra cell drawn) and SHALL set err_overrun, which stays set until reset.
REQ-014 height == 0 SHALL give a one-row frame: frame_done pulses after every cell.
REQ-015 A rising edge and pix_ack in the same cycle while in REQ SHALL be handled as both: the ack completes the pixel and the edge sets err_overrun.

Reset
REQ-016 While reset is low at a clk edge, the block SHALL enter IDLE with:
- pix_req=0, wr_done=1, frame_done=0, err_overrun=0.
- row=0, dx=dy=0, pix_x=pix_y=pix_color=0.
- Registered flag = 0.
REQ-017 Reset mid-cell SHALL abandon the partial cell: pix_req drops at that edge and no further pixels of that cell are written.
REQ-018 node_flag already high when reset releases SHALL count as a rising edge on the first cycle after release.

Configuration
REQ-019 The macro HEAT_RAMP_EN SHALL select the colour encoding:
- When defined: pix_color = {idx[7:5], 3'b000, ~idx[7:6]} (RGB332, blue at cold, red at hot).
- When undefined: pix_color = idx (grayscale).

Verification
REQ-020 Bench SHALL cover, with CELL_LOG2=2, FRAC_BITS=27, X/Y_ORIGIN=0, height=3, col_index=5, and pix_ack high every REQ cycle:
- node_center=32'h0400_0000, flag rise -> 16 writes covering x 20..23, y 12..15, colour 0x80 (0x81 with HEAT_RAMP_EN); wr_done high after DONE.
- node_center=32'hF800_0000 (negative) -> colour 0x00; node_center=32'h1000_0000 -> colour 0xFF.
- Four flag rises with rows 0..3 -> y ranges 12, 8, 4, 0; frame_done pulses once after the fourth cell; row returns to 0.
- pix_ack held low for 10 cycles -> pix_req and the first coordinates stay stable; drawing resumes on ack.
- Flag re-rise during a cell -> cell finishes with 16 writes, no extra cell, err_overrun=1.
- Reset low after the 5th pixel -> pix_req=0, wr_done=1 on the next edge; the next flag rise draws row 0.
